// File: rtl/ram_block_copy.sv
// Block copy engine over a synchronous-read RAM: streams LEN words from src to dst,
// applying copy/add/fill/invert, one word per cycle with an RD_LAT-deep read tracking pipeline.
module ram_block_copy #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic             done,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [DW-1:0]    operand,
    output logic [AW-1:0]    ram_raddr_0,
    input  logic [DW-1:0]    ram_rdata_0,
    output logic [AW-1:0]    ram_waddr_0,
    output logic             ram_wen_0,
    output logic [DW-1:0]    ram_wdata_0,
    output logic [LEN_W-1:0] words_done
);

    localparam logic [1:0]       MODE_COPY = 2'b00;
    localparam logic [1:0]       MODE_ADD  = 2'b01;
    localparam logic [1:0]       MODE_FILL = 2'b10;
    localparam logic [1:0]       MODE_INV  = 2'b11;
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_src;
    logic [AW-1:0]     r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_mode;
    logic [DW-1:0]     r_operand;
    logic [LEN_W-1:0]  r_idx;
    logic              r_done;
    logic [LEN_W-1:0]  r_words_done;

    logic              w_accept;
    logic              w_fill;
    logic              w_issue;
    logic              w_complete;
    logic              w_tail_valid;
    logic [LEN_W-1:0]  w_tail_idx;
    logic [LEN_W-1:0]  w_widx;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_fill     = (r_mode == MODE_FILL);
    assign w_issue    = (r_state == S_ISSUE) && !w_fill;
    assign ready      = (r_state == S_IDLE);
    assign done       = r_done;
    assign words_done = r_words_done;

    // Each stage carries a valid bit and the word index of one outstanding read.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic             r_v;
            logic [LEN_W-1:0] r_i;
            logic             w_v_in;
            logic [LEN_W-1:0] w_i_in;
            if (gi == 0) begin : g_head
                assign w_v_in = w_issue;
                assign w_i_in = r_idx;
            end else begin : g_body
                assign w_v_in = g_stage[gi-1].r_v;
                assign w_i_in = g_stage[gi-1].r_i;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_i <= '0;
                end else begin
                    r_v <= w_v_in;
                    r_i <= w_i_in;
                end
            end
        end
    endgenerate

    assign w_tail_valid = g_stage[RD_LAT-1].r_v;
    assign w_tail_idx   = g_stage[RD_LAT-1].r_i;

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (len != '0)) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_idx == r_len - ONE) begin
                    w_state_next = w_fill ? S_IDLE : S_DRAIN;
                    w_complete   = w_fill;
                end
            end
            S_DRAIN: begin
                if (w_tail_valid && (w_tail_idx == r_len - ONE)) begin
                    w_state_next = S_IDLE;
                    w_complete   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Writes come straight off the pipeline tail so rdata is consumed the cycle it arrives.
    always_comb begin
        ram_raddr_0 = '0;
        ram_wen_0   = 1'b0;
        ram_waddr_0 = '0;
        ram_wdata_0 = '0;
        w_widx      = w_fill ? r_idx : w_tail_idx;
        if (w_issue) ram_raddr_0 = r_src + AW'(r_idx);
        if (((r_state == S_ISSUE) && w_fill) || w_tail_valid) begin
            ram_wen_0   = 1'b1;
            ram_waddr_0 = r_dst + AW'(w_widx);
            case (r_mode)
                MODE_ADD:  ram_wdata_0 = ram_rdata_0 + r_operand;
                MODE_FILL: ram_wdata_0 = r_operand;
                MODE_INV:  ram_wdata_0 = ~ram_rdata_0;
                default:   ram_wdata_0 = ram_rdata_0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_mode       <= MODE_COPY;
            r_operand    <= '0;
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_words_done <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_src        <= src_addr;
                r_dst        <= dst_addr;
                r_len        <= len;
                r_mode       <= mode;
                r_operand    <= operand;
                r_idx        <= '0;
                r_done       <= (len == '0);
                r_words_done <= '0;
            end else begin
                if (r_state == S_ISSUE) r_idx <= r_idx + ONE;
                if (ram_wen_0) r_words_done <= r_words_done + ONE;
                if (w_complete) r_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_block_copy.sv
// Scoreboard bench for ram_block_copy: two instances (RD_LAT=1 and RD_LAT=3), each with a RAM model.
module tb_ram_block_copy;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst     [2];
    logic        start   [2];
    logic        ready   [2];
    logic        done    [2];
    logic [1:0]  mode    [2];
    logic [7:0]  src     [2];
    logic [7:0]  dst     [2];
    logic [15:0] len     [2];
    logic [31:0] op      [2];
    logic [7:0]  raddr   [2];
    logic [31:0] rdata   [2];
    logic [7:0]  waddr   [2];
    logic        wen     [2];
    logic [31:0] wdata   [2];
    logic [15:0] wdone   [2];
    logic        poke_en [2];
    logic [7:0]  poke_a  [2];
    logic [31:0] poke_d  [2];

    wr_t q0[$];
    wr_t q1[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;
            logic [31:0] mem   [256];
            logic [31:0] rpipe [LAT];
            always @(posedge clk) begin
                if (wen[gi]) mem[waddr[gi]] <= wdata[gi];
                else if (poke_en[gi]) mem[poke_a[gi]] <= poke_d[gi];
                rpipe[0] <= mem[raddr[gi]];
                for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
            end
            assign rdata[gi] = rpipe[LAT-1];

            ram_block_copy #(.DW(32), .AW(8), .LEN_W(16), .RD_LAT(LAT)) u_dut (
                .clk(clk), .rst(rst[gi]), .start(start[gi]), .ready(ready[gi]), .done(done[gi]),
                .mode(mode[gi]), .src_addr(src[gi]), .dst_addr(dst[gi]), .len(len[gi]),
                .operand(op[gi]), .ram_raddr_0(raddr[gi]), .ram_rdata_0(rdata[gi]),
                .ram_waddr_0(waddr[gi]), .ram_wen_0(wen[gi]), .ram_wdata_0(wdata[gi]),
                .words_done(wdone[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] peek(input int d, input int a);
        return (d == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
    endfunction

    task automatic poke(input int d, input logic [7:0] a, input logic [31:0] v);
        poke_en[d] = 1'b1; poke_a[d] = a; poke_d[d] = v;
        @(negedge clk);
        poke_en[d] = 1'b0;
    endtask

    task automatic push(input int d, input logic [7:0] a, input logic [31:0] v);
        wr_t e;
        e.a = a; e.d = v;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Monitor: pops one expected write per observed write enable.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (wen[d] === 1'b1) begin
                    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write dut=%0d actual=%0h:%0h required=none",
                                 d, waddr[d], wdata[d]);
                    end else begin
                        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk($sformatf("wr_addr dut%0d", d), 32'(waddr[d]), 32'(e.a));
                        chk($sformatf("wr_data dut%0d", d), wdata[d], e.d);
                    end
                end
            end
        end
    endtask

    task automatic run_job(input int d, input logic [1:0] m, input logic [7:0] s,
                           input logic [7:0] t, input logic [15:0] l, input logic [31:0] o,
                           input int exp_edges, input bit mid);
        int n;
        mode[d] = m; src[d] = s; dst[d] = t; len[d] = l; op[d] = o; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        n = 0;
        if (l != 16'd0) begin
            chk("done_clear", 32'(done[d]), 32'd0);
            chk("wdone_clear", 32'(wdone[d]), 32'd0);
        end
        while (!ready[d] && n < 200) begin
            if (m == 2'b10) chk("fill_raddr", 32'(raddr[d]), 32'd0);
            start[d] = mid && (n == 3);
            if (mid && n == 3) begin src[d] = s + 8'h40; len[d] = 16'd1; end
            @(negedge clk);
            n++;
        end
        start[d] = 1'b0;
        $display("job dut%0d mode=%0d src=%0h dst=%0h len=%0d edges=%0d", d, m, s, t, l, n);
        chk("edges", 32'(n), 32'(exp_edges));
        chk("ready_end", 32'(ready[d]), 32'd1);
        chk("done_end", 32'(done[d]), 32'd1);
        chk("words_done", 32'(wdone[d]), 32'(l));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; start[d] = 1'b0; mode[d] = 2'b00; src[d] = '0; dst[d] = '0;
            len[d] = '0; op[d] = '0; poke_en[d] = 1'b0; poke_a[d] = '0; poke_d[d] = '0;
        end
        fork
            monitor();
        join_none

        // 1: reset then idle
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 32'd1);
            chk("rst_done", 32'(done[d]), 32'd0);
            chk("rst_wen", 32'(wen[d]), 32'd0);
            chk("rst_raddr", 32'(raddr[d]), 32'd0);
            chk("rst_wdone", 32'(wdone[d]), 32'd0);
        end

        // 2: single-word copy
        poke(0, 8'd10, 32'd15);
        push(0, 8'd12, 32'd15);
        run_job(0, 2'b00, 8'd10, 8'd12, 16'd1, 32'd0, 2, 1'b0);
        chk("mem12", peek(0, 12), 32'd15);

        // 3: add with wraparound of the data word
        poke(0, 8'd100, 32'd1);
        poke(0, 8'd101, 32'd2);
        poke(0, 8'd102, 32'd3);
        poke(0, 8'd103, 32'hFFFF_FFFF);
        push(0, 8'd200, 32'd2);
        push(0, 8'd201, 32'd3);
        push(0, 8'd202, 32'd4);
        push(0, 8'd203, 32'd0);
        run_job(0, 2'b01, 8'd100, 8'd200, 16'd4, 32'd1, 5, 1'b0);
        chk("mem203", peek(0, 203), 32'd0);

        // 4: fill, then zero-length job
        for (int i = 0; i < 3; i++) push(0, 8'(50 + i), 32'hA5);
        run_job(0, 2'b10, 8'd0, 8'd50, 16'd3, 32'hA5, 3, 1'b0);
        chk("mem52", peek(0, 52), 32'hA5);
        run_job(0, 2'b00, 8'd10, 8'd60, 16'd0, 32'd0, 0, 1'b0);

        // address wrap: reads 255 then 0
        poke(0, 8'd255, 32'hDEAD_0001);
        poke(0, 8'd0, 32'hDEAD_0002);
        push(0, 8'd20, 32'hDEAD_0001);
        push(0, 8'd21, 32'hDEAD_0002);
        run_job(0, 2'b00, 8'd255, 8'd20, 16'd2, 32'd0, 3, 1'b0);

        // 5: RD_LAT=3 invert with a stray start mid-job
        for (int i = 0; i < 8; i++) begin
            poke(1, 8'(i), 32'h1111_1111 * i);
            push(1, 8'(64 + i), 32'hFFFF_FFFF - 32'h1111_1111 * i);
        end
        run_job(1, 2'b11, 8'd0, 8'd64, 16'd8, 32'd0, 11, 1'b1);
        chk("mem71", peek(1, 71), 32'h8888_8888);

        // 6: reset at edge 4 of an 8-word copy, then restart
        for (int i = 0; i < 8; i++) poke(0, 8'(30 + i), 32'h100 + i);
        poke(0, 8'd83, 32'hBAD);
        for (int i = 0; i < 3; i++) push(0, 8'(80 + i), 32'h100 + i);
        mode[0] = 2'b00; src[0] = 8'd30; dst[0] = 8'd80; len[0] = 16'd8; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_ready", 32'(ready[0]), 32'd1);
        chk("midrst_done", 32'(done[0]), 32'd0);
        chk("midrst_wdone", 32'(wdone[0]), 32'd0);
        chk("midrst_wen", 32'(wen[0]), 32'd0);
        repeat (4) @(negedge clk);
        chk("mem82", peek(0, 82), 32'h102);
        chk("mem83", peek(0, 83), 32'hBAD);
        push(0, 8'd90, 32'h100);
        push(0, 8'd91, 32'h101);
        run_job(0, 2'b00, 8'd30, 8'd90, 16'd2, 32'd0, 3, 1'b0);

        repeat (2) @(negedge clk);
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
